// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Brief    : Shared types and helpers for the synchronous byte-enable SRAM.
// Revision : 1.0 - initial release
// ============================================================================
package sram_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    function automatic int byte_count(input int data_w);
        return data_w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_array.sv
`default_nettype none
// ============================================================================
// Module   : sram_array
// Brief    : Storage array with byte-masked write and registered read-first read.
// Revision : 1.0 - initial release
// ============================================================================
module sram_array
    import sram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     din,
    input  logic                  rd,
    input  logic                  rd_zero,
    output logic [DATA_W-1:0]     rdata
);

    localparam int NB = byte_count(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array: contents survive rst and are only cleared by the sweep.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    // Sampling mem in the same edge as the write yields the pre-write word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd) begin
            rdata <= rd_zero ? '0 : mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_sync_be.sv
`default_nettype none
// ============================================================================
// Module   : sram_sync_be
// Brief    : Synchronous single-port SRAM with byte enables, init sweep and
//            configurable read latency.
// Revision : 1.0 - initial release
// ============================================================================
module sram_sync_be
    import sram_pkg::*;
#(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 8,
    parameter int                 DEPTH    = 256,
    parameter int                 READ_LAT = 1,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  rd,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     din,
    input  logic                  clr,
    output logic [DATA_W-1:0]     dout,
    output logic                  rvalid,
    output logic                  ready
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t                 state;
    logic [ADDR_W-1:0]      cnt;
    logic                   sweeping;
    logic                   accept;
    logic                   in_range;
    logic                   rd_acc;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_din;
    logic [DATA_W/8-1:0]    mem_be;
    logic [DATA_W-1:0]      rdata;
    logic                   v1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (cnt == LAST_ADDR) begin
                        state <= RUN;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                RUN: begin
                    if (clr) begin
                        state <= INIT;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= INIT;
                    cnt   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // ready is high exactly in RUN; a clr in the same cycle suppresses the access.
    assign sweeping = (state == INIT);
    assign accept   = cs & ready & ~clr;
    assign in_range = ({1'b0, addr} < DEPTH_EXT);
    assign rd_acc   = accept & rd;

    assign mem_we   = sweeping | (accept & we & in_range);
    assign mem_addr = sweeping ? cnt : addr;
    assign mem_din  = sweeping ? INIT_VAL : din;
    assign mem_be   = sweeping ? '1 : be;

    sram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we      (mem_we),
        .be      (mem_be),
        .addr    (mem_addr),
        .din     (mem_din),
        .rd      (rd_acc),
        .rd_zero (~in_range),
        .rdata   (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
        end else begin
            v1 <= rd_acc;
        end
    end

    generate
        if (READ_LAT >= READ_LAT_MAX) begin : g_lat2
            logic [DATA_W-1:0] dout_q;
            logic              rvalid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q   <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= v1;
                    if (v1) begin
                        dout_q <= rdata;
                    end
                end
            end

            assign dout   = dout_q;
            assign rvalid = rvalid_q;
        end else begin : g_lat1
            assign dout   = rdata;
            assign rvalid = v1;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sram_sync_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_sync_be
// Brief    : Directed self-checking bench for sram_sync_be (latency 1 and 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_sync_be;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        cs   = 1'b0;
    logic        cs2  = 1'b0;
    logic        we   = 1'b0;
    logic        rd   = 1'b0;
    logic        clr  = 1'b0;
    logic [1:0]  be   = 2'b00;
    logic [7:0]  addr = 8'h00;
    logic [15:0] din  = 16'h0000;

    logic [15:0] dout, dout2;
    logic        rvalid, rvalid2, ready, ready2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_sync_be dut (
        .clk (clk), .rst (rst), .cs (cs), .we (we), .rd (rd), .be (be),
        .addr (addr), .din (din), .clr (clr),
        .dout (dout), .rvalid (rvalid), .ready (ready)
    );

    // Second build: two-cycle latency, partial depth, never cleared.
    sram_sync_be #(.DEPTH (200), .READ_LAT (2)) dut2 (
        .clk (clk), .rst (rst), .cs (cs2), .we (we), .rd (rd), .be (be),
        .addr (addr), .din (din), .clr (1'b0),
        .dout (dout2), .rvalid (rvalid2), .ready (ready2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle;
        cs = 1'b0; cs2 = 1'b0; we = 1'b0; rd = 1'b0; clr = 1'b0; be = 2'b00;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
        cs = 1'b1; we = 1'b1; addr = a; din = d; be = b;
        tick();
        idle();
    endtask

    task automatic rd1(input logic [7:0] a, input logic [15:0] exp, input string tag);
        cs = 1'b1; rd = 1'b1; addr = a;
        tick();
        check({tag, "_dout"}, dout, exp);
        check({tag, "_rvalid"}, 16'(rvalid), 16'h1);
        idle();
    endtask

    task automatic count_init(input string tag);
        for (int i = 1; i <= 256; i++) begin
            tick();
            check({tag, "_ready"}, 16'(ready), 16'(i == 256));
            if (i == 199 || i == 200) begin
                check({tag, "_ready2"}, 16'(ready2), 16'(i == 200));
            end
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst_ready", 16'(ready), 16'h0);
        check("rst_rvalid", 16'(rvalid), 16'h0);
        check("rst_dout", dout, 16'h0000);
        rst = 1'b0;
        count_init("init");

        rd1(8'h2F, 16'h0000, "rd_2f");
        tick();
        check("rd_2f_pulse", 16'(rvalid), 16'h0);

        wr(8'h01, 16'h00A5, 2'b11);
        rd1(8'h01, 16'h00A5, "rd_01");
        tick();
        check("hold_dout", dout, 16'h00A5);
        check("hold_rvalid", 16'(rvalid), 16'h0);

        wr(8'h10, 16'h1234, 2'b11);
        wr(8'h10, 16'hFFFF, 2'b10);
        rd1(8'h10, 16'hFF34, "be_hi");
        wr(8'h10, 16'h0000, 2'b00);
        rd1(8'h10, 16'hFF34, "be_none");

        cs = 1'b1; rd = 1'b1; addr = 8'h01;
        tick();
        check("b2b_0_dout", dout, 16'h00A5);
        check("b2b_0_rvalid", 16'(rvalid), 16'h1);
        addr = 8'h10;
        tick();
        check("b2b_1_dout", dout, 16'hFF34);
        check("b2b_1_rvalid", 16'(rvalid), 16'h1);
        idle();
        tick();
        check("b2b_end_rvalid", 16'(rvalid), 16'h0);

        wr(8'h05, 16'h0021, 2'b11);
        cs = 1'b1; we = 1'b1; rd = 1'b1; addr = 8'h05; din = 16'h0081; be = 2'b11;
        tick();
        check("coll_dout", dout, 16'h0021);
        check("coll_rvalid", 16'(rvalid), 16'h1);
        idle();
        rd1(8'h05, 16'h0081, "coll_after");

        cs = 1'b1; we = 1'b1; addr = 8'h20; din = 16'hBEEF; be = 2'b11; clr = 1'b1;
        tick();
        check("clr_ready", 16'(ready), 16'h0);
        idle();
        cs = 1'b1; rd = 1'b1; addr = 8'h01;
        tick();
        check("init_rd_rvalid", 16'(rvalid), 16'h0);
        check("init_rd_dout", dout, 16'h0081);
        idle();
        for (int i = 2; i <= 256; i++) begin
            tick();
            check("clr_sweep_ready", 16'(ready), 16'(i == 256));
        end
        rd1(8'h01, 16'h0000, "swept_01");
        rd1(8'h10, 16'h0000, "swept_10");
        rd1(8'h20, 16'h0000, "swept_20");

        wr(8'h33, 16'h5A5A, 2'b11);
        rd1(8'h33, 16'h5A5A, "rd_33");
        clr = 1'b1;
        tick();
        idle();
        for (int i = 1; i < 100; i++) begin
            tick();
        end
        // Launch a latency-2 read so a pending rvalid is in flight at reset.
        cs2 = 1'b1; rd = 1'b1; addr = 8'h05;
        tick();
        idle();
        check("midinit_ready", 16'(ready), 16'h0);
        check("midinit_dout_hold", dout, 16'h5A5A);
        rst = 1'b1;
        #1;
        check("arst_dout", dout, 16'h0000);
        check("arst_rvalid2", 16'(rvalid2), 16'h0);
        tick();
        check("arst_ready2", 16'(ready2), 16'h0);
        check("arst_rvalid2_hold", 16'(rvalid2), 16'h0);
        rst = 1'b0;
        count_init("reinit");

        cs2 = 1'b1; we = 1'b1; addr = 8'h05; din = 16'h1357; be = 2'b11;
        tick();
        idle();
        cs2 = 1'b1; rd = 1'b1; addr = 8'h05;
        tick();
        idle();
        check("lat2_e1_rvalid", 16'(rvalid2), 16'h0);
        tick();
        check("lat2_e2_rvalid", 16'(rvalid2), 16'h1);
        check("lat2_e2_dout", dout2, 16'h1357);
        tick();
        check("lat2_e3_rvalid", 16'(rvalid2), 16'h0);
        check("lat2_e3_dout", dout2, 16'h1357);

        cs2 = 1'b1; we = 1'b1; addr = 8'hF0; din = 16'hABCD; be = 2'b11;
        tick();
        idle();
        cs2 = 1'b1; rd = 1'b1; addr = 8'hF0;
        tick();
        idle();
        tick();
        check("oor_rvalid", 16'(rvalid2), 16'h1);
        check("oor_dout", dout2, 16'h0000);

        cs2 = 1'b1; we = 1'b1; addr = 8'hC7; din = 16'h2468; be = 2'b11;
        tick();
        idle();
        cs2 = 1'b1; rd = 1'b1; addr = 8'hC7;
        tick();
        idle();
        tick();
        check("last_word_dout", dout2, 16'h2468);
        check("last_word_rvalid", 16'(rvalid2), 16'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_sync_be.md
Name: sram_sync_be

Overview:
- Parametrised synchronous single-port SRAM. It is the clocked successor to the team's 8-bit combinational sram.
- Adds configurable data/address width and depth, per-byte write enables, and a configurable read latency with an rvalid strobe.
- Adds a hardware initialisation sweep after reset or on request, with a ready flag.
- Sits between bus masters and local storage in the datapath. Used as scratch memory and as a lookup table.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of words; 1 <= DEPTH <= 2**ADDR_W.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).
- INIT_VAL, 0, DATA_W-bit value written to every word during the init sweep.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cs  in  1  chip select; no access takes place unless cs=1.
- we  in  1  write request, qualified by cs.
- rd  in  1  read request, qualified by cs.
- be  in  DATA_W/8  byte write enables; be[i] covers din[8i+7:8i].
- addr  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- clr  in  1  single-cycle request to re-run the init sweep.
- dout  out  DATA_W  read data; holds its value between reads.
- rvalid  out  1  one-cycle pulse, aligned with new dout.
- ready  out  1  high when accesses are accepted.

Behaviour:
- Reset (async, rst=1):
  - Outputs: dout=0, rvalid=0, ready=0.
  - State: state=INIT, init counter=0, latency pipeline cleared.
  - Memory contents are not cleared by reset itself.
- State machine: INIT -> RUN.
  - INIT:
    - Writes INIT_VAL to word[cnt] each cycle and increments cnt.
    - After the cycle that writes DEPTH-1, goes to RUN.
    - ready rises on that same edge, so it is first high exactly DEPTH cycles after the first clk edge with rst=0.
  - RUN:
    - ready=1.
    - clr=1 sampled -> INIT with cnt=0; ready=0 from the next cycle.
    - Any access presented in the same cycle as clr is ignored.
- Access acceptance:
  - An access happens only when cs=1 and ready=1.
  - An access during INIT is dropped silently: no write, no rvalid.
- Write (cs & we):
  - On the edge, word[addr] byte i <= din byte i for each be[i]=1.
  - be=0 means no change.
- Read (cs & rd):
  - READ_LAT=1: dout and rvalid=1 update on the same edge.
  - READ_LAT=2: they update one edge later.
  - rvalid is high for exactly one cycle per accepted read.
  - Back-to-back reads give one rvalid per cycle.
- Read/write collision (we=1 and rd=1 in one cycle):
  - The write is performed.
  - The read returns the pre-write contents (read-first).
- Addresses >= DEPTH:
  - Writes are ignored.
  - Reads return 0, and rvalid is still pulsed.
- clr during INIT is ignored; the current sweep continues.
- Reset mid-INIT or mid-read: immediate return to reset values. Any pending rvalid is discarded. The sweep restarts from 0.
- The latency pipeline keeps running during the INIT transition. A read accepted just before clr still delivers its rvalid.

Decomposition:
- Shared package sram_pkg:
  - state enum {INIT, RUN};
  - READ_LAT legality constants;
  - byte-count helper function (DATA_W/8).
- Sub-module sram_array:
  - storage array;
  - byte-masked write port;
  - registered read-first read port.
- sram_sync_be contains the FSM, init counter, access qualification, latency pipeline and out-of-range handling.

Test Plan:
- Reset/init: release rst and count edges. Required: ready=0 for 255 edges and 1 after edge 256. Then read 0x2F -> dout=0x0000, rvalid high 1 cycle (READ_LAT=1).
- Write/read: write din=0x00A5, addr=0x01, be=2'b11. Next cycle read 0x01 -> dout=0x00A5, rvalid=1 for one cycle. dout holds 0x00A5 afterwards with rvalid=0.
- Byte enables:
  - Write 0x1234 to 0x10 with be=2'b11.
  - Write 0xFFFF to 0x10 with be=2'b10.
  - Read 0x10 -> 0xFF34.
  - Write with be=2'b00 -> word unchanged.
- Collision: with word 0x05=0x0021, assert cs/we/rd with din=0x0081. Required: dout=0x0021. A following read gives 0x0081.
- clr mid-traffic:
  - Pulse clr together with a write to 0x20. Required: the write is dropped and ready falls next cycle.
  - A read during INIT gives no rvalid.
  - 256 cycles later ready=1 and 0x01, 0x10, 0x20 all read 0x0000.
- Reset mid-INIT and latency:
  - Assert rst at cnt=100. Required: ready stays 0 until 256 edges after release.
  - In a READ_LAT=2 build, rvalid appears 2 edges after the read.
  - With DEPTH=200, a read of 0xF0 returns 0 with rvalid.
